// File: rtl/cpu_pkg.sv
// Shared CPU encodings: branch ops, exception causes, PC-stage FSM states and vector-table base.
// Pure declarations, no timing and no handshake.
package cpu_pkg;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_GT = 2'b10,
    BR_LE = 2'b11
  } br_op_e;

  typedef enum logic [1:0] {
    EXC_OPCODE = 2'd0,
    EXC_OVF    = 2'd1,
    EXC_DIV0   = 2'd2,
    EXC_RSVD   = 2'd3
  } exc_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LOAD = 2'd2
  } pc_state_e;

  localparam logic [31:0] VEC_BASE_DEF = 32'd253;

  // The reserved cause has no table entry of its own and shares the invalid-opcode handler.
  function automatic logic [31:0] vec_offset(input logic [1:0] cause);
    if (cause == EXC_RSVD) begin
      return 32'd0;
    end
    return {30'd0, cause};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from ALU flags; purely combinational, zero latency.
// No handshake: the result is valid whenever the inputs are.
module branch_cond
  import cpu_pkg::*;
(
  input  logic [1:0] branch_op,
  input  logic       zero,
  input  logic       gt,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (br_op_e'(branch_op))
      BR_EQ:   cond = zero;
      BR_NE:   cond = ~zero;
      BR_GT:   cond = gt;
      BR_LE:   cond = ~gt;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Architectural PC and EPC with exception entry via a vector-table read; PC writes take 1 cycle,
// exception entry MEM_LATENCY+2 cycles. While exc_busy is high all writes and new exceptions are dropped.
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] VEC_BASE    = VEC_BASE_DEF,
  parameter logic [31:0] EPC_OFFSET  = 32'd4,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_source_in,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        zero,
  input  logic        gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic        vec_req,
  output logic [31:0] vec_addr,
  output logic        exc_busy
);

  localparam int unsigned CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

  pc_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic        vreq_q, vreq_d;
  logic        busy_q, busy_d;
  logic        cond;
  logic        take;
  logic        unused_rdata_hi;

  // Only the low byte of a vector-table entry is a handler address.
  assign unused_rdata_hi = ^mem_rdata[31:8];

  branch_cond u_branch_cond (
    .branch_op (branch_op),
    .zero      (zero),
    .gt        (gt),
    .cond      (cond)
  );

  assign take = pc_write | (pc_write_cond & cond);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      vaddr_q <= '0;
      vreq_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      vaddr_q <= vaddr_d;
      vreq_q  <= vreq_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    vaddr_d = vaddr_q;
    vreq_d  = vreq_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        // An exception wins over any PC write presented in the same cycle.
        if (exc_req) begin
          state_d = ST_REQ;
          cnt_d   = '0;
          epc_d   = pc_q - EPC_OFFSET;
          vaddr_d = VEC_BASE + vec_offset(exc_cause);
          vreq_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (take) begin
          pc_d = pc_source_in;
        end
      end
      ST_REQ: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_LOAD;
          vreq_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LOAD: begin
        pc_d    = {24'd0, mem_rdata[7:0]};
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        vreq_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign pc_out   = pc_q;
  assign epc_out  = epc_q;
  assign vec_req  = vreq_q;
  assign vec_addr = vaddr_q;
  assign exc_busy = busy_q;

endmodule
